// File: rtl/fb_scanout_if.sv
// Framebuffer read port plus pixel-serial video stream of the raster scanout stage.
// master = scanout side (drives addresses and video), slave = framebuffer/PHY side.
interface fb_scanout_if #(
   parameter int XW = 10,
   parameter int YW = 9
);
   logic [XW-1:0] fb_x;
   logic [YW-1:0] fb_y;
   logic          fb_data;
   logic          pix;
   logic          hsync;
   logic          vsync;
   logic          de;
   logic          frame_start;

   modport master (
      output fb_x, fb_y, pix, hsync, vsync, de, frame_start,
      input  fb_data
   );

   modport slave (
      input  fb_x, fb_y, pix, hsync, vsync, de, frame_start,
      output fb_data
   );
endinterface

// File: rtl/fb_scanout.sv
// Raster scanout: video timing counters, 1bpp framebuffer read addressing and sync/de realignment.
// Optional FB_SCANOUT_PIXEL_DOUBLE_EN: halves fb_x/fb_y so each framebuffer pixel fills a 2x2 block.
module fb_scanout #(
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter int SYNC_POL   = 0,
   parameter int FB_WIDTH   = 1024,
   parameter int FB_HEIGHT  = 512,
   parameter int FB_LATENCY = 2
) (
   input  logic         clk,
   input  logic         rst,
   fb_scanout_if.master bus
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW = $clog2(H_TOTAL + 1);
   localparam int VW = $clog2(V_TOTAL + 1);
   localparam int XW = (FB_WIDTH > 2) ? $clog2(FB_WIDTH - 1) : 1;
   localparam int YW = (FB_HEIGHT > 2) ? $clog2(FB_HEIGHT - 1) : 1;

   localparam logic [HW-1:0] H_MAX      = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_START   = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_MAX      = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_START   = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic          SYNC_ACT   = (SYNC_POL != 0);

`ifdef FB_SCANOUT_PIXEL_DOUBLE_EN
   localparam int H_FB_NEED = H_ACTIVE / 2;
   localparam int V_FB_NEED = V_ACTIVE / 2;
`else
   localparam int H_FB_NEED = H_ACTIVE;
   localparam int V_FB_NEED = V_ACTIVE;
`endif

   generate
      if (H_FB_NEED > FB_WIDTH) begin : g_chk_width
         $error("fb_scanout: active width exceeds FB_WIDTH");
      end
      if (V_FB_NEED > FB_HEIGHT) begin : g_chk_height
         $error("fb_scanout: active height exceeds FB_HEIGHT");
      end
      if (FB_LATENCY < 1 || FB_LATENCY > 4) begin : g_chk_latency
         $error("fb_scanout: FB_LATENCY must be within 1..4");
      end
   endgenerate

   logic [HW-1:0] r_hcnt;
   logic [VW-1:0] r_vcnt;

   // Line-end and frame-end wrap on the same edge, so the raster never idles.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hcnt <= '0;
         r_vcnt <= '0;
      end else if (r_hcnt == H_MAX) begin
         r_hcnt <= '0;
         r_vcnt <= (r_vcnt == V_MAX) ? '0 : r_vcnt + 1'b1;
      end else begin
         r_hcnt <= r_hcnt + 1'b1;
      end
   end

   logic       w_h_act;
   logic       w_v_act;
   logic       w_de_raw;
   logic       w_hs_raw;
   logic       w_vs_raw;
   logic       w_fs_raw;
   logic [3:0] w_raw;

   assign w_h_act  = (r_hcnt < H_ACT_END);
   assign w_v_act  = (r_vcnt < V_ACT_END);
   assign w_de_raw = w_h_act && w_v_act;
   assign w_hs_raw = (r_hcnt >= HS_START) && (r_hcnt < HS_END);
   assign w_vs_raw = (r_vcnt >= VS_START) && (r_vcnt < VS_END);
   assign w_fs_raw = (r_hcnt == '0) && (r_vcnt == '0);
   assign w_raw    = {w_de_raw, w_hs_raw, w_vs_raw, w_fs_raw};

   logic [HW-1:0] w_x_src;
   logic [VW-1:0] w_y_src;

`ifdef FB_SCANOUT_PIXEL_DOUBLE_EN
   assign w_x_src = r_hcnt >> 1;
   assign w_y_src = r_vcnt >> 1;
`else
   assign w_x_src = r_hcnt;
   assign w_y_src = r_vcnt;
`endif

   // Addresses are combinational so the framebuffer's own latency is the only delay to match.
   assign bus.fb_x = w_h_act ? XW'(w_x_src) : '0;
   assign bus.fb_y = w_v_act ? YW'(w_y_src) : '0;

   // Timing delay line, FB_LATENCY stages; cleared state means every signal inactive.
   genvar gi;
   generate
      for (gi = 0; gi < FB_LATENCY; gi++) begin : g_dly
         logic [3:0] r_q;
         logic [3:0] w_d;
         if (gi == 0) begin : g_first
            assign w_d = w_raw;
         end else begin : g_next
            assign w_d = g_dly[gi-1].r_q;
         end
         always_ff @(posedge clk) begin
            if (rst) begin
               r_q <= '0;
            end else begin
               r_q <= w_d;
            end
         end
      end
   endgenerate

   logic [3:0] w_dly_out;
   assign w_dly_out = g_dly[FB_LATENCY-1].r_q;

   assign bus.de          = w_dly_out[3];
   assign bus.pix         = w_dly_out[3] & bus.fb_data;
   assign bus.hsync       = w_dly_out[2] ? SYNC_ACT : ~SYNC_ACT;
   assign bus.vsync       = w_dly_out[1] ? SYNC_ACT : ~SYNC_ACT;
   assign bus.frame_start = w_dly_out[0];
endmodule

// File: doc/fb_scanout.md
Name: fb_scanout

Overview:
- Raster scanout stage that sits directly downstream of the 1bpp framebuffer read port.
- Generates video timing counters, drives the framebuffer read coordinates, and realigns the returned pixel bit with delayed sync and data-enable.
- Output is a pixel-serial video stream (pixel, hsync, vsync, de) for the display PHY/encoder.
- Runs on the framebuffer's read-side clock.

Parameters:
- H_ACTIVE, 640, visible pixels per line; must be <= FB_WIDTH.
- H_FP, 16, horizontal front porch, in clocks.
- H_SYNC, 96, hsync pulse width, in clocks.
- H_BP, 48, horizontal back porch, in clocks.
- V_ACTIVE, 480, visible lines; must be <= FB_HEIGHT.
- V_FP, 10, vertical front porch, in lines.
- V_SYNC, 2, vsync pulse width, in lines.
- V_BP, 33, vertical back porch, in lines.
- SYNC_POL, 0, sync active level (0 = active-low).
- FB_WIDTH, 1024, framebuffer line width; sets fb_x width.
- FB_HEIGHT, 512, framebuffer line count; sets fb_y width.
- FB_LATENCY, 2, clocks from fb_x/fb_y to valid fb_data; range 1..4.

Ports:
- clk, input, 1, pixel clock; same clock as framebuffer out_clk.
- rst, input, 1, synchronous active-high reset.
- fb_x, output, $clog2(FB_WIDTH-1), framebuffer read column.
- fb_y, output, $clog2(FB_HEIGHT-1), framebuffer read line.
- fb_data, input, 1, framebuffer read pixel; valid FB_LATENCY clocks after the address.
- pix, output, 1, output pixel.
- hsync, output, 1, horizontal sync at SYNC_POL.
- vsync, output, 1, vertical sync at SYNC_POL.
- de, output, 1, data enable; high for visible pixels only.
- frame_start, output, 1, single-clock pulse coinciding with the first visible pixel of a frame on pix/de.

Behaviour:
- Totals:
  - H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP.
  - V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP.
- Counters:
  - hcnt counts 0..H_TOTAL-1.
  - vcnt advances once per line, when hcnt wraps from H_TOTAL-1 to 0.
  - vcnt counts 0..V_TOTAL-1 and wraps to 0 when both counters are at their maxima.
- Raw timing, combinational from the counters:
  - de_raw = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE).
  - hs_raw active for H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC.
  - vs_raw active for V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC; spans whole lines.
  - fs_raw = (hcnt == 0) && (vcnt == 0).
- Address:
  - fb_x = hcnt while hcnt < H_ACTIVE, else 0.
  - fb_y = vcnt while vcnt < V_ACTIVE, else 0.
  - fb_x and fb_y are combinational from the counters; no address register inside this block.
- Alignment:
  - de_raw, hs_raw, vs_raw and fs_raw pass through an FB_LATENCY-deep shift register.
  - pix = de ? fb_data : 0. Pixels outside the active area are forced to 0.
  - Total latency from counter state to hsync/vsync/de/pix = FB_LATENCY clocks.
  - Sync, de and pix are mutually aligned on every cycle.
- Reset:
  - Counters go to 0 and the delay line clears to inactive.
  - During reset and until the pipeline refills: de=0, pix=0, frame_start=0, hsync=vsync=!SYNC_POL (inactive level).
  - Reset asserted mid-frame restarts timing at (0,0) on the cycle after deassert.
  - First de/frame_start appears FB_LATENCY clocks after reset deassert.
- Wrap boundaries:
  - Line-end and frame-end wraps occur on the same edge; no extra idle cycle.
  - vsync edges align with hcnt==0 of the first/last sync line (after the delay).
- Elaboration checks: error if H_ACTIVE > FB_WIDTH, V_ACTIVE > FB_HEIGHT, or FB_LATENCY is outside 1..4.

Optional Feature:
- Macro: FB_SCANOUT_PIXEL_DOUBLE_EN.
- Defined:
  - fb_x = hcnt>>1 and fb_y = vcnt>>1 within the active area.
  - Each framebuffer pixel is shown as a 2x2 block, e.g. a 320x240 image filling 640x480 timing.
  - The H_ACTIVE <= FB_WIDTH check relaxes to H_ACTIVE/2 <= FB_WIDTH; same for V_ACTIVE against FB_HEIGHT.
- Undefined: 1:1 mapping as described under Behaviour; no shift logic is present.

Test Plan:
- Small timing, FB_LATENCY=2, SYNC_POL=0: H 8/2/2/2, V 4/1/1/1.
  - Bench models fb_data = fb_x[0] ^ fb_y[0] with a 2-clock delay.
  - Required: H_TOTAL=14 and V_TOTAL=7 measured; de high for 8 clocks/line on 4 lines.
  - Required: pix follows the checkerboard pattern.
- Same config, hsync check:
  - hsync low exactly for raw hcnt 10..11, seen on output 2 clocks later.
  - vsync low for all 14 clocks of line 5 (delayed 2).
- frame_start: exactly one pulse per 98 clocks, coincident with the first de; pix then equals the (0,0) pattern value, 0.
- Reset mid-frame (vcnt=2, hcnt=5):
  - Outputs go inactive while reset is held.
  - After release: fb_x=0, fb_y=0 on the next cycle.
  - frame_start 2 clocks after deassert.
- FB_LATENCY=3 with the bench delay changed to match: pix/de/sync alignment is preserved and all outputs shift by 1 clock relative to the FB_LATENCY=2 run.
- FB_SCANOUT_PIXEL_DOUBLE_EN defined, small timing:
  - fb_x sequence per line is 0,0,1,1,2,2,3,3.
  - fb_y sequence over lines is 0,0,1,1.
  - Each framebuffer pixel appears twice horizontally and vertically.
